// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage of the 5-stage MIPS pipeline plus the MEM/WB register.
// Decodes the MEM-stage instruction, performs byte/half/word stores into an
// internal data memory, and sign/zero-extends loads into the WB register.
// Optional build macro: DM_WRITE_LOG_EN (simulation log of every committed store).
module mem_wb_stage #(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_M,
  input  logic [31:0] PC4_M,
  input  logic [31:0] ALUC_M,
  input  logic [31:0] RD2_M,
  output logic [31:0] IR_W,
  output logic [31:0] PC4_W,
  output logic [31:0] ALUC_W,
  output logic [31:0] DR_W,
  output logic        misalign_W
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

  logic [31:0] mem [DM_WORDS];

  logic [5:0]       op_c;
  logic [DM_AW-1:0] widx_c;
  logic [1:0]       off_c;
  size_e            size_c;
  logic             is_load_c;
  logic             is_store_c;
  logic             sext_c;
  logic             misalign_c;
  logic             we_c;
  logic [31:0]      rd_word_c;
  logic [31:0]      lane_c;
  logic [31:0]      load_data_c;
  logic [31:0]      dr_next_c;
  logic [31:0]      wr_word_c;

  assign op_c   = IR_M[31:26];
  assign widx_c = ALUC_M[DM_AW+1:2];
  assign off_c  = ALUC_M[1:0];

  // Opcode decode: access size, direction and extension mode
  always_comb begin
    size_c     = SZ_NONE;
    is_load_c  = 1'b0;
    is_store_c = 1'b0;
    sext_c     = 1'b0;
    case (op_c)
      OP_LW:  begin size_c = SZ_WORD; is_load_c = 1'b1; end
      OP_LH:  begin size_c = SZ_HALF; is_load_c = 1'b1; sext_c = 1'b1; end
      OP_LHU: begin size_c = SZ_HALF; is_load_c = 1'b1; end
      OP_LB:  begin size_c = SZ_BYTE; is_load_c = 1'b1; sext_c = 1'b1; end
      OP_LBU: begin size_c = SZ_BYTE; is_load_c = 1'b1; end
      OP_SW:  begin size_c = SZ_WORD; is_store_c = 1'b1; end
      OP_SH:  begin size_c = SZ_HALF; is_store_c = 1'b1; end
      OP_SB:  begin size_c = SZ_BYTE; is_store_c = 1'b1; end
      default: ;
    endcase
  end

  // Alignment check; byte accesses and non-memory ops never fault
  assign misalign_c = ((size_c == SZ_WORD) && (off_c != 2'b00)) ||
                      ((size_c == SZ_HALF) && off_c[0]);
  assign we_c       = is_store_c && !misalign_c;

  // Asynchronous read of the addressed word, lane shifted down to bit 0
  assign rd_word_c = mem[widx_c];
  assign lane_c    = rd_word_c >> {off_c, 3'b000};

  // Load lane selection and extension
  always_comb begin
    load_data_c = 32'h0;
    case (size_c)
      SZ_WORD: load_data_c = rd_word_c;
      SZ_HALF: load_data_c = sext_c ? {{16{lane_c[15]}}, lane_c[15:0]}
                                    : {16'h0, lane_c[15:0]};
      SZ_BYTE: load_data_c = sext_c ? {{24{lane_c[7]}}, lane_c[7:0]}
                                    : {24'h0, lane_c[7:0]};
      default: load_data_c = 32'h0;
    endcase
  end

  assign dr_next_c = (is_load_c && !misalign_c) ? load_data_c : 32'h0;

  // Store lane merge: untouched lanes keep the current word contents
  always_comb begin
    wr_word_c = rd_word_c;
    case (size_c)
      SZ_WORD: wr_word_c = RD2_M;
      SZ_HALF: wr_word_c[{off_c[1], 4'b0000} +: 16] = RD2_M[15:0];
      SZ_BYTE: wr_word_c[{off_c, 3'b000} +: 8]      = RD2_M[7:0];
      default: wr_word_c = rd_word_c;
    endcase
  end

  // Data memory: cleared on reset, otherwise commits aligned stores
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (we_c) begin
      mem[widx_c] <= wr_word_c;
`ifdef DM_WRITE_LOG_EN
      $display("@%h: *%h <= %h", PC4_M - 32'd4, {ALUC_M[31:2], 2'b00}, wr_word_c);
`endif
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      IR_W       <= 32'h0;
      PC4_W      <= 32'h0;
      ALUC_W     <= 32'h0;
      DR_W       <= 32'h0;
      misalign_W <= 1'b0;
    end else begin
      IR_W       <= IR_M;
      PC4_W      <= PC4_M;
      ALUC_W     <= ALUC_M;
      DR_W       <= dr_next_c;
      misalign_W <= misalign_c;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, reset corner
// sequence, then randomized traffic against a byte-addressed reference model.
module tb_mem_wb_stage;

  localparam int DM_BYTES = 4096;

  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] SW  = 6'h2B;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SB  = 6'h28;

  logic        clk;
  logic        reset;
  logic [31:0] IR_M, PC4_M, ALUC_M, RD2_M;
  logic [31:0] IR_W, PC4_W, ALUC_W, DR_W;
  logic        misalign_W;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] bmem [DM_BYTES];

  mem_wb_stage dut (
    .clk       (clk),
    .reset     (reset),
    .IR_M      (IR_M),
    .PC4_M     (PC4_M),
    .ALUC_M    (ALUC_M),
    .RD2_M     (RD2_M),
    .IR_W      (IR_W),
    .PC4_W     (PC4_W),
    .ALUC_W    (ALUC_W),
    .DR_W      (DR_W),
    .misalign_W(misalign_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc4;
    logic [31:0] aluc;
    logic [31:0] rd2;
    logic [31:0] dr;
    logic        mis;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [31:0] ins(input logic [5:0] op);
    return {op, 5'd3, 5'd4, 16'h0010};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Present one MEM-stage instruction, then sample just after the edge
  task automatic drive(input logic [31:0] ir, input logic [31:0] pc4,
                       input logic [31:0] aluc, input logic [31:0] rd2);
    IR_M   = ir;
    PC4_M  = pc4;
    ALUC_M = aluc;
    RD2_M  = rd2;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string nm, input logic [31:0] ir, input logic [31:0] pc4,
                            input logic [31:0] aluc, input logic [31:0] dr, input logic mis);
    check({nm, ".IR_W"},   IR_W,   ir);
    check({nm, ".PC4_W"},  PC4_W,  pc4);
    check({nm, ".ALUC_W"}, ALUC_W, aluc);
    check({nm, ".DR_W"},   DR_W,   dr);
    check({nm, ".mis"},    {31'h0, misalign_W}, {31'h0, mis});
  endtask

  // Reference model: byte-addressed memory, loads assembled byte by byte
  task automatic model_step(input logic [31:0] ir, input logic [31:0] aluc,
                            input logic [31:0] rd2, output logic [31:0] dr, output logic mis);
    int     sz;
    bit     ld;
    bit     sx;
    int     a;
    longint v;
    sz = 0; ld = 0; sx = 0;
    case (ir[31:26])
      LW:  begin sz = 4; ld = 1; end
      LH:  begin sz = 2; ld = 1; sx = 1; end
      LHU: begin sz = 2; ld = 1; end
      LB:  begin sz = 1; ld = 1; sx = 1; end
      LBU: begin sz = 1; ld = 1; end
      SW:  sz = 4;
      SH:  sz = 2;
      SB:  sz = 1;
      default: sz = 0;
    endcase
    a   = int'(aluc % DM_BYTES);
    dr  = 32'h0;
    mis = 1'b0;
    if (sz != 0) begin
      mis = (a % sz) != 0;
      if (!mis) begin
        if (ld) begin
          v = 0;
          for (int k = 0; k < sz; k++) v = v + (longint'(bmem[a + k]) << (8 * k));
          if (sx && sz == 1 && v >= 128)   v = v - 256;
          if (sx && sz == 2 && v >= 32768) v = v - 65536;
          dr = 32'(v);
        end else begin
          for (int k = 0; k < sz; k++) bmem[a + k] = 8'(rd2 >> (8 * k));
        end
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DM_BYTES; i++) bmem[i] = 8'h0;
  endtask

  initial begin
    logic [31:0] exp_dr;
    logic        exp_mis;
    logic [31:0] r, ir, aluc, rd2, pc4, hi;
    logic [5:0]  ops [9];
    int          sel;

    ops = '{LW, LH, LHU, LB, LBU, SW, SH, SB, 6'h00};

    // Reset with a store pending
    reset = 1'b1;
    drive(ins(SW), 32'h4, 32'h0, 32'hFFFF_FFFF);
    drive(ins(SW), 32'h8, 32'h4, 32'h1234_5678);
    check_outs("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;

    tbl[0]  = '{ins(SW),  32'h104,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{ins(LW),  32'h108,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{ins(SB),  32'h10C,  32'h13,   32'h000000AA, 32'h0,        1'b0};
    tbl[3]  = '{ins(LB),  32'h110,  32'h13,   32'h0,        32'hFFFFFFAA, 1'b0};
    tbl[4]  = '{ins(LBU), 32'h114,  32'h13,   32'h0,        32'h000000AA, 1'b0};
    tbl[5]  = '{ins(LW),  32'h118,  32'h10,   32'h0,        32'hAAADBEEF, 1'b0};
    tbl[6]  = '{ins(SH),  32'h11C,  32'h22,   32'h00008001, 32'h0,        1'b0};
    tbl[7]  = '{ins(LH),  32'h120,  32'h22,   32'h0,        32'hFFFF8001, 1'b0};
    tbl[8]  = '{ins(LHU), 32'h124,  32'h22,   32'h0,        32'h00008001, 1'b0};
    tbl[9]  = '{ins(LW),  32'h128,  32'h20,   32'h0,        32'h80010000, 1'b0};
    tbl[10] = '{ins(SW),  32'h12C,  32'h06,   32'h12345678, 32'h0,        1'b1};
    tbl[11] = '{ins(LW),  32'h130,  32'h04,   32'h0,        32'h0,        1'b0};
    tbl[12] = '{ins(LH),  32'h134,  32'h01,   32'h0,        32'h0,        1'b1};
    tbl[13] = '{32'h0022_5820, 32'h3004, 32'h1234, 32'h9, 32'h0,          1'b0};
    tbl[14] = '{ins(SW),  32'h138,  32'h1000, 32'h00000055, 32'h0,        1'b0};
    tbl[15] = '{ins(LW),  32'h13C,  32'h0,    32'h0,        32'h00000055, 1'b0};
    tbl[16] = '{32'h0,    32'h140,  32'h10,   32'h0,        32'h0,        1'b0};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].ir, tbl[i].pc4, tbl[i].aluc, tbl[i].rd2);
      check_outs($sformatf("vec%0d", i), tbl[i].ir, tbl[i].pc4, tbl[i].aluc,
                 tbl[i].dr, tbl[i].mis);
    end

    // Reset while a store sits in MEM: store dropped, memory cleared
    reset = 1'b1;
    drive(ins(SW), 32'h200, 32'h0, 32'h0000_0077);
    check_outs("rst_store", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    drive(ins(LW), 32'h204, 32'h0, 32'h0);
    check("rst_clr.w0", DR_W, 32'h0);
    drive(ins(LW), 32'h208, 32'h10, 32'h0);
    check("rst_clr.w4", DR_W, 32'h0);
    drive(ins(LW), 32'h20C, 32'h20, 32'h0);
    check("rst_clr.w8", DR_W, 32'h0);

    // Randomized traffic in a small window, sometimes with upper address bits set
    model_clear();
    for (int n = 0; n < 600; n++) begin
      r    = $urandom();
      sel  = $urandom_range(0, 9);
      if (sel == 9) ir = r;
      else          ir = {ops[sel], r[25:0]};
      aluc = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) begin
        hi   = $urandom();
        aluc = aluc | (hi & 32'hFFFF_F000);
      end
      rd2  = $urandom();
      pc4  = $urandom();
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        drive(ir, pc4, aluc, rd2);
        check_outs($sformatf("rnd%0d_rst", n), 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        model_clear();
        reset = 1'b0;
      end else begin
        model_step(ir, aluc, rd2, exp_dr, exp_mis);
        drive(ir, pc4, aluc, rd2);
        check_outs($sformatf("rnd%0d", n), ir, pc4, aluc, exp_dr, exp_mis);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
